bus_slave_responder: RTL and testbench

- Slave-side end of the system bus command protocol; answers master-issued read/write commands.
- Holds a local byte memory.
- Accepts one command (address, burst length, direction), then moves burst data beat-by-beat under valid/ready handshakes.
- Signals completion to the bus with tx_done (write) or rx_done (read), one-cycle pulses.

---
 rtl/bus_slave_if.sv | 30 +++
 rtl/bus_slave_responder.sv | 124 ++++++++++++
 tb/tb_bus_slave_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_if.sv
// Bus command/data signals between the system bus master and a slave responder.
// The master drives command, write data and read-ready; the slave answers with read data and status.
interface bus_slave_if #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
);
    logic                 sel;
    logic [1:0]           instruction;
    logic [ADDR_LEN-1:0]  address;
    logic [BURST_LEN-1:0] burst_num;
    logic [DATA_LEN-1:0]  wr_data;
    logic                 wr_valid;
    logic                 rd_ready;
    logic [DATA_LEN-1:0]  rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 tx_done;
    logic                 rx_done;

    modport master (
        output sel, instruction, address, burst_num, wr_data, wr_valid, rd_ready,
        input  rd_data, rd_valid, busy, tx_done, rx_done
    );

    modport slave (
        input  sel, instruction, address, burst_num, wr_data, wr_valid, rd_ready,
        output rd_data, rd_valid, busy, tx_done, rx_done
    );
endinterface

// File: rtl/bus_slave_responder.sv
// Slave end of the bus command protocol: accepts one read/write burst command and
// moves data beat-by-beat between the bus and a local byte memory.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting for sel && instruction[1]
//   WRITE    | storing one beat per wr_valid, stalls while wr_valid low
//   RD_FETCH | registered memory read of the current address
//   RD_HOLD  | rd_valid high, rd_data held until rd_ready
//   DONE     | one-cycle tx_done (write) or rx_done (read) pulse
module bus_slave_responder #(
    parameter int ADDR_LEN     = 12,
    parameter int DATA_LEN     = 8,
    parameter int BURST_LEN    = 12,
    parameter int MEM_ADDR_LEN = 12
) (
    input  logic        clk,
    input  logic        reset,
    bus_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_FETCH = 3'd2,
        RD_HOLD  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [MEM_ADDR_LEN-1:0] ADDR_STEP = MEM_ADDR_LEN'(1);
    localparam logic [BURST_LEN-1:0]    BEAT_STEP = BURST_LEN'(1);

    state_t                  state_q, state_d;
    logic [MEM_ADDR_LEN-1:0] cur_addr_q, cur_addr_d;
    logic [BURST_LEN-1:0]    remaining_q, remaining_d;
    logic                    dir_q, dir_d;
    logic                    mem_we;
    logic                    fetch;
    logic [DATA_LEN-1:0]     rd_data_q;

    logic [DATA_LEN-1:0]     mem [0:(1<<MEM_ADDR_LEN)-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        mem_we      = 1'b0;
        fetch       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sel && bus.instruction[1]) begin
                    cur_addr_d  = bus.address[MEM_ADDR_LEN-1:0];
                    remaining_d = bus.burst_num;
                    dir_d       = bus.instruction[0];
                    state_d     = bus.instruction[0] ? RD_FETCH : WRITE;
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    mem_we      = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_STEP;
                    remaining_d = remaining_q - BEAT_STEP;
                    if (remaining_q == '0) begin
                        state_d = DONE;
                    end
                end
            end
            RD_FETCH: begin
                fetch   = 1'b1;
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                if (bus.rd_ready) begin
                    cur_addr_d  = cur_addr_q + ADDR_STEP;
                    remaining_d = remaining_q - BEAT_STEP;
                    state_d     = (remaining_q == '0) ? DONE : RD_FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory is never reset; the reset gate keeps an aborted beat from landing.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[cur_addr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (fetch) begin
            rd_data_q <= mem[cur_addr_q];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = (state_q == RD_HOLD);
    assign bus.busy     = (state_q == WRITE) || (state_q == RD_FETCH) || (state_q == RD_HOLD);
    assign bus.tx_done  = (state_q == DONE) && !dir_q;
    assign bus.rx_done  = (state_q == DONE) && dir_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench for bus_slave_responder: writes, reads back, stalls, wrap, ignored
// commands and mid-burst reset, each step checked against hand-computed values.
module tb_bus_slave_responder;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bus_slave_if #(.ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12)) bus ();

    bus_slave_responder #(
        .ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12), .MEM_ADDR_LEN(12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(bus.busy),     0);
        check({tag, "_rdvalid"}, 32'(bus.rd_valid), 0);
        check({tag, "_txdone"},  32'(bus.tx_done),  0);
        check({tag, "_rxdone"},  32'(bus.rx_done),  0);
    endtask

    // Presents a command for exactly one edge, then removes it.
    task automatic cmd(input logic rd, input logic [11:0] addr, input logic [11:0] bn);
        bus.sel         = 1'b1;
        bus.instruction = {1'b1, rd};
        bus.address     = addr;
        bus.burst_num   = bn;
        cyc();
        bus.sel         = 1'b0;
        bus.instruction = 2'b00;
        check("cmd_busy", 32'(bus.busy), 1);
    endtask

    task automatic wbeat(input logic [7:0] d, input logic last);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        cyc();
        bus.wr_valid = 1'b0;
        check("wbeat_txdone", 32'(bus.tx_done), 32'(last));
        check("wbeat_busy",   32'(bus.busy),    32'(!last));
    endtask

    // Entered with the responder in RD_FETCH.
    task automatic rbeat(input logic [7:0] exp, input int stall, input logic last);
        check("rfetch_valid", 32'(bus.rd_valid), 0);
        cyc();
        check("rhold_valid", 32'(bus.rd_valid), 1);
        check("rhold_data",  32'(bus.rd_data),  32'(exp));
        for (int i = 0; i < stall; i++) begin
            cyc();
            check("rstall_valid", 32'(bus.rd_valid), 1);
            check("rstall_data",  32'(bus.rd_data),  32'(exp));
        end
        bus.rd_ready = 1'b1;
        cyc();
        bus.rd_ready = 1'b0;
        check("rpost_valid",  32'(bus.rd_valid), 0);
        check("rpost_rxdone", 32'(bus.rx_done),  32'(last));
        check("rpost_txdone", 32'(bus.tx_done),  0);
    endtask

    task automatic after_done();
        cyc();
        check_idle_outputs("after_done");
    endtask

    initial begin
        reset           = 1'b1;
        bus.sel         = 1'b0;
        bus.instruction = 2'b00;
        bus.address     = '0;
        bus.burst_num   = '0;
        bus.wr_data     = '0;
        bus.wr_valid    = 1'b0;
        bus.rd_ready    = 1'b0;
        cyc();
        cyc();
        check_idle_outputs("reset");
        check("reset_rddata", 32'(bus.rd_data), 0);
        reset = 1'b0;
        cyc();

        // single write then single read
        cmd(1'b0, 12'h005, 12'd0);
        wbeat(8'hA5, 1'b1);
        after_done();
        cmd(1'b1, 12'h005, 12'd0);
        rbeat(8'hA5, 0, 1'b1);
        after_done();

        // 4-beat write with a 3-cycle wr_valid gap between beats 2 and 3
        cmd(1'b0, 12'h010, 12'd3);
        wbeat(8'h11, 1'b0);
        wbeat(8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("wgap_busy",   32'(bus.busy),    1);
            check("wgap_txdone", 32'(bus.tx_done), 0);
        end
        wbeat(8'h33, 1'b0);
        wbeat(8'h44, 1'b1);
        after_done();
        cyc();
        check("single_txdone", 32'(bus.tx_done), 0);

        // 3-beat read with a 5-cycle rd_ready stall on beat 2
        cmd(1'b1, 12'h010, 12'd2);
        rbeat(8'h11, 0, 1'b0);
        rbeat(8'h22, 5, 1'b0);
        rbeat(8'h33, 0, 1'b1);
        after_done();

        // address wrap from 0xFFF to 0x000
        cmd(1'b0, 12'hFFF, 12'd1);
        wbeat(8'h7E, 1'b0);
        wbeat(8'h7F, 1'b1);
        after_done();
        cmd(1'b1, 12'hFFF, 12'd1);
        rbeat(8'h7E, 0, 1'b0);
        rbeat(8'h7F, 0, 1'b1);
        after_done();
        cmd(1'b1, 12'h000, 12'd0);
        rbeat(8'h7F, 0, 1'b1);
        after_done();

        // unselected start and selected no-start are both ignored, as are idle data strobes
        bus.instruction = 2'b10;
        bus.address     = 12'h005;
        bus.wr_valid    = 1'b1;
        bus.wr_data     = 8'hEE;
        cyc();
        check_idle_outputs("nosel");
        bus.sel         = 1'b1;
        bus.instruction = 2'b00;
        cyc();
        check_idle_outputs("nostart");
        bus.sel      = 1'b0;
        bus.wr_valid = 1'b0;
        cmd(1'b1, 12'h005, 12'd0);
        rbeat(8'hA5, 0, 1'b1);
        after_done();

        // new commands during WRITE and during DONE change nothing
        cmd(1'b0, 12'h020, 12'd1);
        bus.sel         = 1'b1;
        bus.instruction = 2'b11;
        bus.address     = 12'h030;
        bus.burst_num   = 12'd5;
        wbeat(8'h55, 1'b0);
        wbeat(8'h66, 1'b1);
        cyc();
        bus.sel         = 1'b0;
        bus.instruction = 2'b00;
        check_idle_outputs("done_cmd");
        cyc();
        check_idle_outputs("done_cmd2");
        cmd(1'b1, 12'h020, 12'd1);
        rbeat(8'h55, 0, 1'b0);
        rbeat(8'h66, 0, 1'b1);
        after_done();

        // reset after beat 1 of a 4-beat write
        cmd(1'b0, 12'h041, 12'd0);
        wbeat(8'h5A, 1'b1);
        after_done();
        cmd(1'b0, 12'h040, 12'd3);
        wbeat(8'h99, 1'b0);
        reset        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hCC;
        cyc();
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        check_idle_outputs("midreset");
        check("midreset_rddata", 32'(bus.rd_data), 0);
        cyc();
        check_idle_outputs("midreset2");
        cmd(1'b0, 12'h050, 12'd0);
        wbeat(8'hBB, 1'b1);
        after_done();
        cmd(1'b1, 12'h040, 12'd1);
        rbeat(8'h99, 0, 1'b0);
        rbeat(8'h5A, 0, 1'b1);
        after_done();
        cmd(1'b1, 12'h050, 12'd0);
        rbeat(8'hBB, 0, 1'b1);
        after_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
